// File: rtl/nibble_add_seq.sv
// Sequences a W-bit add through an external 4-bit adder slice, LS nibble first.
// Define NIBBLE_ADD_OVF_EN to add the signed-overflow output ovf.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c0,
  input  logic [3:0]             add_f,
  input  logic                   add_c4,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r, b_r;
  logic          carry;
  logic [IW-1:0] idx;

  // Slice operands come straight from the latched registers so the adder sees
  // them for the whole RUN cycle; zeroed elsewhere to keep the slice quiet.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state == RUN) begin
      add_a  = a_r[4*idx +: 4];
      add_b  = b_r[4*idx +: 4];
      add_c0 = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cout  <= 1'b0;
      sum   <= '0;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= op_a;
            b_r   <= op_b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef NIBBLE_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= add_f;
          carry           <= add_c4;
          if (idx == LAST) begin
            cout  <= add_c4;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
`ifdef NIBBLE_ADD_OVF_EN
            // add_f[3] is the sum MSB being written on this same edge
            ovf   <= (a_r[W-1] == b_r[W-1]) && (add_f[3] != a_r[W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
